// File: rtl/hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : hs_rr_arbiter
// Brief    : Round-robin arbiter forwarding one of N 4-phase req/ack channels
//            to a shared 4-phase resource, with synchronized async inputs.
// Revision : 1.0 - initial release
// ============================================================================
module hs_rr_arbiter #(
    parameter int N           = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    output logic [N-1:0] ack,
    output logic [N-1:0] gnt,
    output logic         r_req,
    input  logic         r_ack,
    output logic         busy
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FWD     = 2'd1,
        S_GRANTED = 2'd2,
        S_RTZ     = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0][N-1:0] r_req_sync;
    logic [SYNC_STAGES-1:0]        r_ack_sync;
    logic [N-1:0]                  w_req_s;
    logic                          w_ack_s;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [PTR_W-1:0]              r_ptr;
    logic [PTR_W-1:0]              r_own;
    logic [PTR_W-1:0]              w_ptr_nxt;
    logic [PTR_W-1:0]              w_own_nxt;
    logic [N-1:0]                  w_gnt_nxt;
    logic [N-1:0]                  w_ack_nxt;
    logic                          w_rreq_nxt;

    logic                          w_found;
    logic [PTR_W-1:0]              w_winner;
    logic [PTR_W:0]                w_sum;
    logic [PTR_W-1:0]              w_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_sync <= '0;
            r_ack_sync <= '0;
        end else begin
            r_req_sync <= {r_req_sync[SYNC_STAGES-2:0], req};
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], r_ack};
        end
    end

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

    // First synchronized requester at or after the pointer, wrapping modulo N
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        w_idx    = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && w_req_s[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = gnt;
        w_ack_nxt   = ack;
        w_rreq_nxt  = r_req;
        case (r_state)
            S_IDLE: begin
                // A resource still acknowledging (e.g. after reset) blocks new grants
                if (w_found && !w_ack_s) begin
                    w_state_nxt         = S_FWD;
                    w_own_nxt           = w_winner;
                    w_gnt_nxt           = '0;
                    w_gnt_nxt[w_winner] = 1'b1;
                    w_rreq_nxt          = 1'b1;
                end
            end
            S_FWD: begin
                if (w_ack_s) begin
                    w_state_nxt      = S_GRANTED;
                    w_ack_nxt        = '0;
                    w_ack_nxt[r_own] = 1'b1;
                end
            end
            S_GRANTED: begin
                if (!w_req_s[r_own]) begin
                    w_state_nxt = S_RTZ;
                    w_rreq_nxt  = 1'b0;
                end
            end
            S_RTZ: begin
                if (!w_ack_s) begin
                    w_state_nxt = S_IDLE;
                    w_ack_nxt   = '0;
                    w_gnt_nxt   = '0;
                    w_ptr_nxt   = (r_own == PTR_W'(N-1)) ? '0 : r_own + PTR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_own   <= '0;
            gnt     <= '0;
            ack     <= '0;
            r_req   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_own   <= w_own_nxt;
            gnt     <= w_gnt_nxt;
            ack     <= w_ack_nxt;
            r_req   <= w_rreq_nxt;
            busy    <= (w_state_nxt != S_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hs_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_hs_rr_arbiter
// Brief    : Directed self-checking bench for hs_rr_arbiter (N=4, 2 sync stages).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hs_rr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] ack;
    logic [N-1:0] gnt;
    logic         r_req;
    logic         r_ack;
    logic         busy;

    logic         auto_res = 1'b1;
    logic         man_ack  = 1'b0;
    logic [4:0]   dl       = '0;
    bit           mon_en   = 1'b0;
    int           n_checks = 0;
    int           n_errors = 0;

    hs_rr_arbiter #(.N(N), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .ack   (ack),
        .gnt   (gnt),
        .r_req (r_req),
        .r_ack (r_ack),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    // Ideal resource: r_ack follows r_req five clock edges later
    always @(posedge clk) dl <= {dl[3:0], r_req};
    assign r_ack = auto_res ? dl[4] : man_ack;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("mutex", {29'd0, ($countones(gnt) <= 1), ($countones(ack) <= 1),
                          (busy || (gnt == '0))}, 32'd7);
        end
    end

    task automatic wait_gnt(input string tag);
        for (int c = 0; c < 100 && gnt == '0; c++) @(negedge clk);
        chk(tag, {31'd0, gnt != '0}, 32'd1);
    endtask

    task automatic wait_ack(input string tag, input int i, input logic v);
        for (int c = 0; c < 100 && ack[i] !== v; c++) @(negedge clk);
        chk(tag, {31'd0, ack[i]}, {31'd0, v});
    endtask

    task automatic wait_rack(input string tag, input logic v);
        for (int c = 0; c < 100 && r_ack !== v; c++) @(negedge clk);
        chk(tag, {31'd0, r_ack}, {31'd0, v});
    endtask

    task automatic wait_rreq(input string tag, input logic v);
        for (int c = 0; c < 100 && r_req !== v; c++) @(negedge clk);
        chk(tag, {31'd0, r_req}, {31'd0, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int e;
        rst = 1'b1;
        req = 4'b1111;

        // Reset held for three cycles with every requester active
        repeat (3) begin
            @(negedge clk);
            chk("rst_ack",  ack,   0);
            chk("rst_gnt",  gnt,   0);
            chk("rst_rreq", r_req, 0);
            chk("rst_busy", busy,  0);
        end
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_ptr", dut.r_ptr, 0);

        // Round-robin with all requesting: order 0,1,2,3,0,1
        for (int t = 0; t < 6; t++) begin
            e = t % 4;
            wait_gnt("rr_wait_gnt");
            chk("rr_order", gnt, 32'(1 << e));
            wait_ack("rr_ack_up", e, 1'b1);
            if (t == 5) req = '0;
            else        req[e] = 1'b0;
            wait_ack("rr_ack_dn", e, 1'b0);
            if (t < 5) req[e] = 1'b1;
        end
        chk("rr_ptr",  dut.r_ptr, 2);
        chk("rr_busy", busy,      0);

        // Single handshake on requester 2 with exact latencies
        @(negedge clk);
        req = 4'b0100;
        repeat (2) @(negedge clk);
        chk("sh_rreq_early", r_req, 0);
        @(negedge clk);
        chk("sh_rreq_up", r_req, 1);
        chk("sh_gnt",     gnt,   4'b0100);
        wait_rack("sh_rack_up", 1'b1);
        repeat (2) @(negedge clk);
        chk("sh_ack_early", ack, 0);
        @(negedge clk);
        chk("sh_ack_up", ack, 4'b0100);
        req = '0;
        repeat (2) @(negedge clk);
        chk("sh_rreq_hold", r_req, 1);
        @(negedge clk);
        chk("sh_rreq_dn",  r_req, 0);
        chk("sh_gnt_held", gnt,   4'b0100);
        wait_rack("sh_rack_dn", 1'b0);
        repeat (2) @(negedge clk);
        chk("sh_ack_hold", ack, 4'b0100);
        @(negedge clk);
        chk("sh_ack_dn", ack,       0);
        chk("sh_gnt_dn", gnt,       0);
        chk("sh_busy",   busy,      0);
        chk("sh_ptr",    dut.r_ptr, 3);

        // Wrap-around from pointer 3: requester 3 first, then 0
        req = 4'b1001;
        wait_gnt("wr_wait1");
        chk("wr_first", gnt, 4'b1000);
        wait_ack("wr_ack3_up", 3, 1'b1);
        req[3] = 1'b0;
        wait_ack("wr_ack3_dn", 3, 1'b0);
        wait_gnt("wr_wait2");
        chk("wr_second", gnt, 4'b0001);
        wait_ack("wr_ack0_up", 0, 1'b1);
        req[0] = 1'b0;
        wait_ack("wr_ack0_dn", 0, 1'b0);
        chk("wr_ptr", dut.r_ptr, 1);

        // Premature withdrawal of requester 1 while forwarding
        req = 4'b0010;
        wait_gnt("wd_wait");
        chk("wd_gnt",   gnt,   4'b0010);
        chk("wd_rack0", r_ack, 0);
        req = '0;
        wait_ack("wd_ack_up", 1, 1'b1);
        chk("wd_rreq_granted", r_req, 1);
        @(negedge clk);
        chk("wd_rtz_rreq", r_req, 0);
        chk("wd_rtz_ack",  ack,   4'b0010);
        wait_ack("wd_ack_dn", 1, 1'b0);
        chk("wd_gnt_dn", gnt,       0);
        chk("wd_ptr",    dut.r_ptr, 2);

        // Reset in GRANTED with the resource acknowledge stuck high
        @(negedge clk);
        auto_res = 1'b0;
        man_ack  = 1'b0;
        req      = 4'b0001;
        wait_rreq("rm_rreq_up", 1'b1);
        man_ack = 1'b1;
        wait_ack("rm_ack_up", 0, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk("rm_ack",  ack,   0);
        chk("rm_gnt",  gnt,   0);
        chk("rm_rreq", r_req, 0);
        chk("rm_busy", busy,  0);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("rm_stuck_rreq", r_req, 0);
        end
        man_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rm_rreq_early", r_req, 0);
        @(negedge clk);
        chk("rm_rreq_up2", r_req, 1);
        chk("rm_gnt2",     gnt,   4'b0001);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
